// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for the MIPS150 core: serialises I-fetch and D-side
// load/store requests onto one memory port, one transaction in flight at a time.
module mem_port_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    output logic            i_rvalid,
    output logic [DW-1:0]   i_rdata,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [DW/8-1:0] d_be,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    output logic            d_rvalid,
    output logic [DW-1:0]   d_rdata,
    output logic            m_req,
    output logic            m_we,
    output logic [DW/8-1:0] m_be,
    output logic [AW-1:0]   m_addr,
    output logic [DW-1:0]   m_wdata,
    input  logic            m_ready,
    input  logic            m_rvalid,
    input  logic [DW-1:0]   m_rdata,
    output logic            stall
);
    localparam int BW = DW / 8;
    localparam int CW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t          state_reg;
    logic [CW-1:0]   starve_cnt_reg;
    logic            grant_i_reg;
    logic            m_req_reg;
    logic            m_we_reg;
    logic [BW-1:0]   m_be_reg;
    logic [AW-1:0]   m_addr_reg;
    logic [DW-1:0]   m_wdata_reg;
    logic            i_rvalid_reg;
    logic            d_rvalid_reg;
    logic [DW-1:0]   i_rdata_reg;
    logic [DW-1:0]   d_rdata_reg;

    // I-side only overrides data priority once it has been passed over STARVE_MAX times.
    logic starved;
    logic grant_d;
    assign starved = i_req && (starve_cnt_reg == CW'(STARVE_MAX));
    assign grant_d = d_req && !starved;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            starve_cnt_reg <= '0;
            grant_i_reg    <= 1'b0;
            m_req_reg      <= 1'b0;
            m_we_reg       <= 1'b0;
            m_be_reg       <= '0;
            m_addr_reg     <= '0;
            m_wdata_reg    <= '0;
            i_rvalid_reg   <= 1'b0;
            d_rvalid_reg   <= 1'b0;
            i_rdata_reg    <= '0;
            d_rdata_reg    <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_req || d_req) begin
                        m_req_reg <= 1'b1;
                        state_reg <= ISSUE;
                        if (grant_d) begin
                            grant_i_reg <= 1'b0;
                            m_we_reg    <= d_we;
                            m_be_reg    <= d_be;
                            m_addr_reg  <= d_addr;
                            m_wdata_reg <= d_wdata;
                            if (i_req && (starve_cnt_reg < CW'(STARVE_MAX)))
                                starve_cnt_reg <= starve_cnt_reg + CW'(1);
                        end else begin
                            grant_i_reg    <= 1'b1;
                            m_we_reg       <= 1'b0;
                            m_be_reg       <= '1;
                            m_addr_reg     <= i_addr;
                            starve_cnt_reg <= '0;
                        end
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        m_req_reg <= 1'b0;
                        state_reg <= WAIT;
                    end
                end
                WAIT: begin
                    if (m_rvalid) begin
                        state_reg <= RESP;
                        if (grant_i_reg) begin
                            i_rvalid_reg <= 1'b1;
                            i_rdata_reg  <= m_rdata;
                        end else begin
                            d_rvalid_reg <= 1'b1;
                            // Stores only get the ack pulse; load data stays intact.
                            if (!m_we_reg)
                                d_rdata_reg <= m_rdata;
                        end
                    end
                end
                RESP: begin
                    i_rvalid_reg <= 1'b0;
                    d_rvalid_reg <= 1'b0;
                    state_reg    <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign m_req    = m_req_reg;
    assign m_we     = m_we_reg;
    assign m_be     = m_be_reg;
    assign m_addr   = m_addr_reg;
    assign m_wdata  = m_wdata_reg;
    assign i_rvalid = i_rvalid_reg;
    assign d_rvalid = d_rvalid_reg;
    assign i_rdata  = i_rdata_reg;
    assign d_rdata  = d_rdata_reg;
    assign stall    = (i_req & ~i_rvalid_reg) | (d_req & ~d_rvalid_reg);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single memory port of the MIPS150 core between instruction fetch (I-side, read-only) and load/store (D-side, read/write with byte enables).
- Sits between the datapath and the unified block-RAM/MMIO port.
- Serialises requests with one outstanding transaction at a time.
- Provides data-over-fetch priority with starvation protection, and produces the pipeline stall.

Parameters:
- AW, 32, address width.
- DW, 32, data width; byte-enable width is DW/8.
- STARVE_MAX, 4, consecutive D-grants made while i_req is pending before I-side is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- i_req  in  1  fetch request; held until i_rvalid.
- i_addr  in  AW  fetch address.
- i_rvalid  out  1  one-cycle fetch response pulse.
- i_rdata  out  DW  fetch data, valid with i_rvalid.
- d_req  in  1  data request; held until d_rvalid.
- d_we  in  1  1 = store.
- d_be  in  DW/8  store byte enables.
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_rvalid  out  1  one-cycle load data / store ack pulse.
- d_rdata  out  DW  load data, valid with d_rvalid.
- m_req  out  1  memory request valid.
- m_we  out  1  memory write.
- m_be  out  DW/8  memory byte enables.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_ready  in  1  memory accepts request when m_req & m_ready.
- m_rvalid  in  1  memory response (read data or write ack).
- m_rdata  in  DW  memory read data.
- stall  out  1  datapath stall.

Behaviour:
- Reset:
  - State IDLE, starve_cnt = 0.
  - m_req, m_we, i_rvalid, d_rvalid = 0.
  - m_be, m_addr, m_wdata, i_rdata, d_rdata = 0.
  - Reset mid-transaction aborts it: no response pulse is emitted, and the memory is reset by the same rst.
- FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
- IDLE:
  - If no request, stay in IDLE.
  - Otherwise arbitrate, latch the winner's id/addr/we/be/wdata into the m_* registers, set m_req = 1, go to ISSUE.
  - An I-side grant forces m_we = 0 and m_be = all ones.
- Arbitration:
  - D wins if d_req, unless i_req && starve_cnt == STARVE_MAX, in which case I wins.
  - starve_cnt: cleared on any I grant; incremented (saturating at STARVE_MAX) on a D grant while i_req = 1; unchanged on a D grant with i_req = 0.
- ISSUE:
  - Hold all m_* outputs stable while m_ready = 0.
  - On m_req & m_ready, drop m_req next cycle and go to WAIT.
- WAIT:
  - On m_rvalid, capture m_rdata into i_rdata or d_rdata per the latched id.
  - Pulse the matching *_rvalid next cycle; go to RESP.
  - For stores, d_rdata is not updated; d_rvalid serves as the ack.
- m_rvalid is ignored outside WAIT. The memory guarantees m_rvalid is at least 1 cycle after acceptance.
- RESP:
  - Exactly one *_rvalid is high for one cycle.
  - No arbitration in this cycle; next state is IDLE.
  - Requesters sample *_rvalid and may change req/fields at the following edge.
- Minimum latency, with m_ready = 1 and memory response latency 1: req seen at cycle t, m_req at t+1, m_rvalid at t+2, *_rvalid at t+3, next arbitration at t+4.
- Request fields must stay stable while req is high and unserved; the arbiter reads them only in IDLE.
- i_rdata and d_rdata hold their last value between pulses.
- stall (combinational) = (i_req & ~i_rvalid) | (d_req & ~d_rvalid).
- Simultaneous i_req and d_req in IDLE resolve per the arbitration rule; the loser stays pending, with stall held high.
- Back-pressure: m_ready low for N cycles extends ISSUE by N cycles, with no output change.

Test Plan:
- Reset, then i_req, addr 0x100, m_ready = 1, memory latency 1, m_rdata 0x2402000A:
  - m_req at t+1 with m_addr 0x100, m_we 0.
  - i_rvalid at t+3 with i_rdata 0x2402000A.
  - stall high t..t+2, low at t+3.
- Store d_req, d_we 1, d_be 4'b0011, addr 0x204, wdata 0xDEADBEEF:
  - m_we 1, m_be 0011, m_wdata 0xDEADBEEF.
  - d_rvalid pulse; d_rdata unchanged.
- i_req and d_req both high continuously with STARVE_MAX = 4:
  - Grant order is D, D, D, D, I, D, D, D, D, I…
  - starve_cnt clears after each I grant.
- m_ready held low 5 cycles during ISSUE:
  - m_req, m_addr and m_wdata stay stable for 5 cycles.
  - Exactly one m_req & m_ready handshake occurs; single response.
- Spurious m_rvalid in IDLE or ISSUE: no *_rvalid pulse, no data capture.
- rst asserted in WAIT:
  - Next cycle state is IDLE and all outputs are 0.
  - A later m_rvalid produces no pulse.
  - A new i_req after reset completes normally.
